// File: rtl/frog_pkg.sv
// rtl/frog_pkg.sv - shared types and keycode constants for the frog sprite sequencer
package frog_pkg;

    typedef enum logic [1:0] {
        UP    = 2'd0,
        RIGHT = 2'd1,
        DOWN  = 2'd2,
        LEFT  = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        JUMP = 2'd1,
        LAND = 2'd2,
        DEAD = 2'd3
    } hop_state_t;

    localparam int JUMP_BIT = 2;

    localparam logic [7:0] KEY_W = 8'h1A;
    localparam logic [7:0] KEY_A = 8'h04;
    localparam logic [7:0] KEY_S = 8'h16;
    localparam logic [7:0] KEY_D = 8'h07;

endpackage

// File: rtl/frog_hop_ctrl_if.sv
// rtl/frog_hop_ctrl_if.sv - control/status bundle between game logic and the frog sequencer
interface frog_hop_ctrl_if;
    logic       frame_tick;
    logic [7:0] keycode;
    logic       die;
    logic       respawn;
    logic [9:0] frog_x;
    logic [9:0] frog_y;
    logic [2:0] dir;
    logic       busy;
    logic       hop_done;
    logic       dead;

    modport master (
        output frame_tick, keycode, die, respawn,
        input  frog_x, frog_y, dir, busy, hop_done, dead
    );

    modport slave (
        input  frame_tick, keycode, die, respawn,
        output frog_x, frog_y, dir, busy, hop_done, dead
    );
endinterface

// File: rtl/frog_key_edge.sv
// rtl/frog_key_edge.sv - keycode history and new-press detection with direction decode
module frog_key_edge
    import frog_pkg::*;
(
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic [7:0] keycode,
    output logic       press,
    output dir_t       press_dir
);

    logic [7:0] prev_code;
    logic       key_valid;

    // Remember last cycle's code so a held key produces only one press.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            prev_code <= 8'd0;
        end else begin
            prev_code <= keycode;
        end
    end

    // Decode WASD; a press is a valid direction code that changed since last cycle.
    always_comb begin
        key_valid = 1'b1;
        press_dir = UP;
        case (keycode)
            KEY_W:   press_dir = UP;
            KEY_D:   press_dir = RIGHT;
            KEY_S:   press_dir = DOWN;
            KEY_A:   press_dir = LEFT;
            default: key_valid = 1'b0;
        endcase
        press = key_valid && (keycode != prev_code);
    end

endmodule

// File: rtl/frog_hop_ctrl.sv
// rtl/frog_hop_ctrl.sv - frog hop sequencer; define FROG_KEY_QUEUE_EN for a one-deep press queue
module frog_hop_ctrl
    import frog_pkg::*;
#(
    parameter int STEP_PX         = 24,
    parameter int HOP_FRAMES      = 4,
    parameter int COOLDOWN_FRAMES = 2,
    parameter int X_MAX           = 616,
    parameter int Y_MAX           = 456,
    parameter int START_X         = 312,
    parameter int START_Y         = 456
) (
    input  logic             Clk,
    input  logic             Reset_n,
    frog_hop_ctrl_if.slave   bus
);

    localparam int MOVE_PX = STEP_PX / HOP_FRAMES;

    hop_state_t state;
    logic [9:0] x_r;
    logic [9:0] y_r;
    logic [2:0] dir_r;
    logic       busy_r;
    logic       hop_done_r;
    logic       dead_r;
    logic [7:0] hop_cnt;
    logic [7:0] land_cnt;
    logic [9:0] tgt_x_r;
    logic [9:0] tgt_y_r;

    logic       press;
    dir_t       press_dir;
    logic       take;
    dir_t       take_dir;
    logic [10:0] tgt_x;
    logic [10:0] tgt_y;
    logic        in_range;

    frog_key_edge u_key_edge (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .keycode   (bus.keycode),
        .press     (press),
        .press_dir (press_dir)
    );

`ifdef FROG_KEY_QUEUE_EN
    logic q_valid;
    dir_t q_dir;

    // Hold the latest press seen while busy; drained on the first IDLE cycle.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            q_valid <= 1'b0;
            q_dir   <= UP;
        end else if (bus.die || bus.respawn) begin
            q_valid <= 1'b0;
        end else if ((state == JUMP || state == LAND) && press) begin
            q_valid <= 1'b1;
            q_dir   <= press_dir;
        end else if (state == IDLE) begin
            q_valid <= 1'b0;
        end
    end

    assign take     = (state == IDLE) && (press || q_valid);
    assign take_dir = press ? press_dir : q_dir;
`else
    assign take     = (state == IDLE) && press;
    assign take_dir = press_dir;
`endif

    // Hop target in 11 bits so stepping below zero lands far above the legal range.
    always_comb begin
        tgt_x = {1'b0, x_r};
        tgt_y = {1'b0, y_r};
        case (take_dir)
            UP:      tgt_y = {1'b0, y_r} - 11'(STEP_PX);
            DOWN:    tgt_y = {1'b0, y_r} + 11'(STEP_PX);
            LEFT:    tgt_x = {1'b0, x_r} - 11'(STEP_PX);
            default: tgt_x = {1'b0, x_r} + 11'(STEP_PX);
        endcase
        in_range = (tgt_x <= 11'(X_MAX)) && (tgt_y <= 11'(Y_MAX));
    end

    // Hop FSM: die beats respawn, respawn beats normal sequencing.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state      <= IDLE;
            x_r        <= 10'(START_X);
            y_r        <= 10'(START_Y);
            dir_r      <= 3'd0;
            busy_r     <= 1'b0;
            hop_done_r <= 1'b0;
            dead_r     <= 1'b0;
            hop_cnt    <= 8'd0;
            land_cnt   <= 8'd0;
            tgt_x_r    <= 10'd0;
            tgt_y_r    <= 10'd0;
        end else begin
            hop_done_r <= 1'b0;
            if (bus.die) begin
                state           <= DEAD;
                dir_r[JUMP_BIT] <= 1'b0;
                dead_r          <= 1'b1;
                busy_r          <= 1'b0;
            end else if (bus.respawn) begin
                state  <= IDLE;
                x_r    <= 10'(START_X);
                y_r    <= 10'(START_Y);
                dir_r  <= 3'd0;
                dead_r <= 1'b0;
                busy_r <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (take) begin
                            dir_r[1:0] <= take_dir;
                            if (in_range) begin
                                state           <= JUMP;
                                dir_r[JUMP_BIT] <= 1'b1;
                                busy_r          <= 1'b1;
                                hop_cnt         <= 8'd0;
                                tgt_x_r         <= tgt_x[9:0];
                                tgt_y_r         <= tgt_y[9:0];
                            end
                        end
                    end
                    JUMP: begin
                        if (bus.frame_tick) begin
                            hop_cnt <= hop_cnt + 8'd1;
                            if (hop_cnt == 8'(HOP_FRAMES - 1)) begin
                                x_r             <= tgt_x_r;
                                y_r             <= tgt_y_r;
                                dir_r[JUMP_BIT] <= 1'b0;
                                hop_done_r      <= 1'b1;
                                land_cnt        <= 8'd0;
                                state           <= LAND;
                            end else begin
                                case (dir_t'(dir_r[1:0]))
                                    UP:      y_r <= y_r - 10'(MOVE_PX);
                                    DOWN:    y_r <= y_r + 10'(MOVE_PX);
                                    LEFT:    x_r <= x_r - 10'(MOVE_PX);
                                    default: x_r <= x_r + 10'(MOVE_PX);
                                endcase
                            end
                        end
                    end
                    LAND: begin
                        if (bus.frame_tick) begin
                            land_cnt <= land_cnt + 8'd1;
                            if (land_cnt == 8'(COOLDOWN_FRAMES - 1)) begin
                                state  <= IDLE;
                                busy_r <= 1'b0;
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign bus.frog_x   = x_r;
    assign bus.frog_y   = y_r;
    assign bus.dir      = dir_r;
    assign bus.busy     = busy_r;
    assign bus.hop_done = hop_done_r;
    assign bus.dead     = dead_r;

endmodule

// File: tb/tb_frog_hop_ctrl.sv
// tb/tb_frog_hop_ctrl.sv - self-checking bench for frog_hop_ctrl
module tb_frog_hop_ctrl;
    import frog_pkg::*;

    logic Clk = 1'b0;
    logic Reset_n = 1'b0;
    always #5 Clk = ~Clk;

    frog_hop_ctrl_if bus ();

    frog_hop_ctrl dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int mx = 312;
    int my = 456;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic tick();
        bus.frame_tick = 1'b1;
        cyc();
        bus.frame_tick = 1'b0;
    endtask

    task automatic press(input logic [7:0] code);
        bus.keycode = code;
        cyc();
        bus.keycode = 8'd0;
    endtask

    function automatic logic [7:0] code_of(input int d);
        case (d)
            0: return 8'h1A;
            1: return 8'h07;
            2: return 8'h16;
            default: return 8'h04;
        endcase
    endfunction

    function automatic int dx(input int d);
        return (d == 1) ? 1 : (d == 3) ? -1 : 0;
    endfunction

    function automatic int dy(input int d);
        return (d == 2) ? 1 : (d == 0) ? -1 : 0;
    endfunction

    // Model: one press followed by enough frame ticks to complete hop and cooldown.
    task automatic hop(input int d);
        int  tx;
        int  ty;
        bit  ok;
        tx = mx + 24 * dx(d);
        ty = my + 24 * dy(d);
        ok = (tx >= 0) && (tx <= 616) && (ty >= 0) && (ty <= 456);
        press(code_of(d));
        if (!ok) begin
            chk("blocked_dir", 32'(bus.dir), 32'(d));
            chk("blocked_busy", 32'(bus.busy), 32'd0);
            chk("blocked_x", 32'(bus.frog_x), 32'(mx));
            chk("blocked_y", 32'(bus.frog_y), 32'(my));
        end else begin
            chk("jump_dir", 32'(bus.dir), 32'(4 + d));
            chk("jump_busy", 32'(bus.busy), 32'd1);
            for (int k = 1; k <= 4; k++) begin
                cyc();
                tick();
                chk("hop_x", 32'(bus.frog_x), 32'(mx + 6 * k * dx(d)));
                chk("hop_y", 32'(bus.frog_y), 32'(my + 6 * k * dy(d)));
                chk("hop_done", 32'(bus.hop_done), (k == 4) ? 32'd1 : 32'd0);
            end
            chk("land_dir", 32'(bus.dir), 32'(d));
            cyc();
            chk("hop_done_clear", 32'(bus.hop_done), 32'd0);
            chk("land_busy", 32'(bus.busy), 32'd1);
            tick();
            cyc();
            tick();
            chk("idle_busy", 32'(bus.busy), 32'd0);
            mx = tx;
            my = ty;
        end
    endtask

    initial begin
        int done_cnt;
        bus.frame_tick = 1'b0;
        bus.keycode    = 8'd0;
        bus.die        = 1'b0;
        bus.respawn    = 1'b0;
        Reset_n        = 1'b0;
        repeat (3) cyc();
        chk("rst_x", 32'(bus.frog_x), 32'd312);
        chk("rst_y", 32'(bus.frog_y), 32'd456);
        chk("rst_dir", 32'(bus.dir), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_hop_done", 32'(bus.hop_done), 32'd0);
        chk("rst_dead", 32'(bus.dead), 32'd0);
        Reset_n = 1'b1;
        cyc();

        // Basic up hop, back down, then a blocked down press at the bottom edge.
        hop(0);
        hop(2);
        hop(2);
        tick();
        chk("blocked_no_move", 32'(bus.frog_y), 32'd456);

        // Held key: exactly one hop.
        done_cnt = 0;
        bus.keycode = 8'h07;
        for (int i = 0; i < 20; i++) begin
            cyc();
            tick();
            if (bus.hop_done === 1'b1) done_cnt++;
        end
        bus.keycode = 8'd0;
        cyc();
        chk("hold_hops", 32'(done_cnt), 32'd1);
        chk("hold_x", 32'(bus.frog_x), 32'd336);
        chk("hold_busy", 32'(bus.busy), 32'd0);
        mx = 336;

        // Death mid-hop freezes, die beats respawn, respawn restores spawn.
        press(8'h07);
        cyc();
        tick();
        cyc();
        tick();
        bus.die = 1'b1;
        cyc();
        bus.die = 1'b0;
        chk("die_dead", 32'(bus.dead), 32'd1);
        chk("die_x", 32'(bus.frog_x), 32'd348);
        chk("die_dir", 32'(bus.dir), 32'd1);
        chk("die_busy", 32'(bus.busy), 32'd0);
        tick();
        cyc();
        tick();
        chk("dead_frozen_x", 32'(bus.frog_x), 32'd348);
        bus.die = 1'b1;
        bus.respawn = 1'b1;
        cyc();
        bus.die = 1'b0;
        bus.respawn = 1'b0;
        chk("die_wins", 32'(bus.dead), 32'd1);
        bus.respawn = 1'b1;
        cyc();
        bus.respawn = 1'b0;
        chk("respawn_x", 32'(bus.frog_x), 32'd312);
        chk("respawn_y", 32'(bus.frog_y), 32'd456);
        chk("respawn_dir", 32'(bus.dir), 32'd0);
        chk("respawn_dead", 32'(bus.dead), 32'd0);
        mx = 312;
        my = 456;

        // die and respawn together from IDLE.
        bus.die = 1'b1;
        bus.respawn = 1'b1;
        cyc();
        bus.die = 1'b0;
        bus.respawn = 1'b0;
        chk("idle_die_wins", 32'(bus.dead), 32'd1);
        bus.respawn = 1'b1;
        cyc();
        bus.respawn = 1'b0;
        chk("idle_respawn_dead", 32'(bus.dead), 32'd0);

        // Respawn mid-hop teleports to spawn and idles.
        press(8'h1A);
        cyc();
        tick();
        chk("tele_pre_y", 32'(bus.frog_y), 32'd450);
        bus.respawn = 1'b1;
        cyc();
        bus.respawn = 1'b0;
        chk("tele_y", 32'(bus.frog_y), 32'd456);
        chk("tele_busy", 32'(bus.busy), 32'd0);
        tick();
        chk("tele_still", 32'(bus.frog_y), 32'd456);

        // Reset mid-hop.
        press(8'h1A);
        cyc();
        tick();
        cyc();
        tick();
        Reset_n = 1'b0;
        cyc();
        Reset_n = 1'b1;
        chk("midrst_y", 32'(bus.frog_y), 32'd456);
        chk("midrst_dir", 32'(bus.dir), 32'd0);
        chk("midrst_busy", 32'(bus.busy), 32'd0);

        // Press during a hop: queued or discarded depending on build.
        press(8'h1A);
        cyc();
        tick();
        cyc();
        tick();
        press(8'h07);
        repeat (10) begin
            cyc();
            tick();
        end
        repeat (3) cyc();
`ifdef FROG_KEY_QUEUE_EN
        mx = 336;
`else
        mx = 312;
`endif
        my = 432;
        chk("queue_x", 32'(bus.frog_x), 32'(mx));
        chk("queue_y", 32'(bus.frog_y), 32'(my));
        chk("queue_busy", 32'(bus.busy), 32'd0);

        // Walk to the top-left corner, then hit both edges.
        while (mx >= 24) hop(3);
        hop(3);
        while (my >= 24) hop(0);
        hop(0);

        // Random walk against the model.
        for (int i = 0; i < 40; i++) begin
            hop(int'($urandom_range(0, 3)));
        end
        chk("final_x", 32'(bus.frog_x), 32'(mx));
        chk("final_y", 32'(bus.frog_y), 32'(my));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
